// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian walk and night flash.
// Main road rests in green until a demand arrives after its minimum green.
// The side road then gets a fixed green, with a walk interval if a pedestrian
// request is pending at side-green entry. All durations count tick pulses.
// Parameters must satisfy WALK <= SIDE_GREEN and every duration >= 1.
// The current phase code is exported on 'state' so checkers can bind to it.
module traffic_phase_scheduler #(
  parameter int MAIN_MIN   = 8,
  parameter int SIDE_GREEN = 5,
  parameter int YELLOW     = 2,
  parameter int ALLRED     = 1,
  parameter int WALK       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       flash,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter is wide enough to hold the longest duration and the WALK bound.
  localparam int MAX_D = max2(max2(MAIN_MIN, SIDE_GREEN), max2(YELLOW, ALLRED));
  localparam int CW    = $clog2(MAX_D + 1);

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    AR_SIDE = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_Y  = 3'd4,
    AR_MAIN = 3'd5,
    FLASH   = 3'd6
  } phase_t;

  phase_t          cur_state;
  phase_t          nxt_state;
  logic [CW-1:0]   cnt;
  logic            blink;
  logic            served;
  logic            leave;
  logic            main_min_done;
  logic            cnt_run;
  logic            enter_side_g;

  assign main_min_done = (cnt == CW'(MAIN_MIN - 1));
  assign leave         = (nxt_state != cur_state);
  assign enter_side_g  = leave && (nxt_state == SIDE_G);
  // MAIN_G saturates once its minimum is met; FLASH does not use the counter.
  assign cnt_run       = tick && (cur_state != FLASH) &&
                         !((cur_state == MAIN_G) && main_min_done);
  assign state         = cur_state;

  // Next-phase selection: timed exits on the tick that completes the duration.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      MAIN_G:  if (tick && main_min_done &&
                   (side_req || ped_pending || ped_req || flash)) nxt_state = MAIN_Y;
      MAIN_Y:  if (tick && cnt == CW'(YELLOW - 1))     nxt_state = AR_SIDE;
      AR_SIDE: if (tick && cnt == CW'(ALLRED - 1))     nxt_state = flash ? FLASH : SIDE_G;
      SIDE_G:  if (tick && cnt == CW'(SIDE_GREEN - 1)) nxt_state = SIDE_Y;
      SIDE_Y:  if (tick && cnt == CW'(YELLOW - 1))     nxt_state = AR_MAIN;
      AR_MAIN: if (tick && cnt == CW'(ALLRED - 1))     nxt_state = flash ? FLASH : MAIN_G;
      FLASH:   if (tick && !flash)                     nxt_state = AR_MAIN;
      default:                                         nxt_state = AR_MAIN;
    endcase
  end

  // Phase register and tick counter; the counter restarts on every phase entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= AR_MAIN;
      cnt       <= '0;
    end else begin
      cur_state <= nxt_state;
      if (leave)        cnt <= '0;
      else if (cnt_run) cnt <= cnt + CW'(1);
    end
  end

  // Flash blink: cleared on FLASH entry, toggled on each tick while flashing.
  always_ff @(posedge clk) begin
    if (rst)                              blink <= 1'b0;
    else if (leave && nxt_state == FLASH) blink <= 1'b0;
    else if (cur_state == FLASH && tick)  blink <= ~blink;
  end

  // Pedestrian latch: a request on the side-green entry edge is served at once
  // instead of being latched; later requests wait for the next side green.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending <= 1'b0;
      served      <= 1'b0;
    end else if (enter_side_g) begin
      ped_pending <= 1'b0;
      served      <= ped_pending | ped_req;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end
  end

  // Moore lamp and walk decode from registered state ([2]=red,[1]=yellow,[0]=green).
  always_comb begin
    main_rgy = 3'b100;
    side_rgy = 3'b100;
    walk     = 1'b0;
    case (cur_state)
      MAIN_G: main_rgy = 3'b001;
      MAIN_Y: main_rgy = 3'b010;
      SIDE_G: begin
        side_rgy = 3'b001;
        walk     = served && (cnt < CW'(WALK));
      end
      SIDE_Y: side_rgy = 3'b010;
      FLASH: begin
        main_rgy = {1'b0, blink, 1'b0};
        side_rgy = {blink, 2'b00};
      end
      default: begin
        main_rgy = 3'b100;
        side_rgy = 3'b100;
      end
    endcase
  end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter MAIN_MIN, 8: minimum main-road green, in ticks.
REQ-002 Parameter SIDE_GREEN, 5: side-road green duration, in ticks.
REQ-003 Parameter YELLOW, 2: yellow duration, in ticks, for either road.
REQ-004 Parameter ALLRED, 1: all-red clearance duration, in ticks.
REQ-005 Parameter WALK, 4: pedestrian walk duration, in ticks; the block SHALL require WALK <= SIDE_GREEN and all durations >= 1.
REQ-006 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 tick  in  1  one-cycle timebase pulse; all durations count tick pulses.
REQ-009 side_req  in  1  side-road vehicle sensor, level.
REQ-010 ped_req  in  1  pedestrian button, pulse or level.
REQ-011 flash  in  1  request for flashing (night) mode, level.
REQ-012 main_rgy  out  3  main-road lamps: [2]=red, [1]=yellow, [0]=green.
REQ-013 side_rgy  out  3  side-road lamps, same encoding as main_rgy.
REQ-014 walk  out  1  pedestrian walk signal for crossing the main road.
REQ-015 ped_pending  out  1  latched, unserved pedestrian request.
REQ-016 state  out  3  current phase code.

Function
REQ-017 State codes SHALL be: MAIN_G=0, MAIN_Y=1, AR_SIDE=2, SIDE_G=3, SIDE_Y=4, AR_MAIN=5, FLASH=6; code 7 SHALL go to AR_MAIN on the next clock.
REQ-018 Phase counter cnt SHALL clear on every state entry and increment only on cycles with tick=1.
REQ-019 A timed state of duration D SHALL exit on the clock edge where tick=1 and cnt==D-1, i.e. after exactly D ticks.
REQ-020 MAIN_G: cnt SHALL saturate at MAIN_MIN-1; on a tick with cnt==MAIN_MIN-1 and (side_req | ped_pending | ped_req | flash), go to MAIN_Y; otherwise stay in MAIN_G indefinitely.
REQ-021 Timed sequence: MAIN_Y(YELLOW) -> AR_SIDE(ALLRED) -> SIDE_G(SIDE_GREEN) -> SIDE_Y(YELLOW) -> AR_MAIN(ALLRED) -> MAIN_G.
REQ-022 On exit from AR_SIDE or AR_MAIN with flash=1, the next state SHALL be FLASH instead of the normal successor.
REQ-023 FLASH: a blink bit SHALL toggle on every tick; main_rgy={0,blink,0} and side_rgy={blink,0,0}.
REQ-024 FLASH exit: on a tick with flash=0, go to AR_MAIN; blink SHALL clear on FLASH entry.
REQ-025 ped_pending SHALL set on any cycle with ped_req=1, except the SIDE_G entry edge.
REQ-026 On the edge entering SIDE_G: serve = ped_pending | ped_req; ped_pending SHALL clear; a served flag SHALL load serve.
REQ-027 walk SHALL be 1 in SIDE_G while served=1 and cnt < WALK; otherwise 0.
REQ-028 ped_req during SIDE_G after entry SHALL set ped_pending for the next cycle and SHALL NOT extend the current walk.
REQ-029 Lamp outputs SHALL be decoded from the registered state (Moore) and change on the same edge as the state.
REQ-030 Lamp decode: MAIN_G 001/100; MAIN_Y 010/100; AR_SIDE and AR_MAIN 100/100; SIDE_G 100/001; SIDE_Y 100/010 (main/side).
REQ-031 No state other than SIDE_G SHALL assert walk; main and side SHALL never both show green or yellow.

Reset
REQ-032 With rst=1 sampled, on that edge: state=AR_MAIN, cnt=0, blink=0, served=0, ped_pending=0.
REQ-033 Reset outputs SHALL be main_rgy=100, side_rgy=100, walk=0; rst SHALL override tick, ped_req and flash.
REQ-034 Reset mid-operation, including in SIDE_G with walk=1, SHALL yield the reset values on the next edge.

Verification
REQ-035 Reset for 2 cycles -> state=5, both lamps 100, walk=0; 1 tick later -> state=0, main_rgy=001.
REQ-036 No demand for 50 ticks -> state stays 0, cnt holds at 7.
REQ-037 side_req=1 from tick 2 of MAIN_G -> MAIN_Y after the 8th tick, then 2/1/5/2/1 ticks through states 1..5, then back to 0; walk stays 0.
REQ-038 ped_req pulse in MAIN_G -> ped_pending=1; at SIDE_G entry ped_pending=0 and walk=1 for exactly 4 ticks, then 0 for 1 tick.
REQ-039 ped_req on the SIDE_G entry edge -> served this phase, ped_pending=0; ped_req at SIDE_G tick 2 -> ped_pending=1, walk not extended.
REQ-040 flash=1 during SIDE_G -> FLASH after AR_MAIN, blink toggles each tick; flash=0 -> AR_MAIN then MAIN_G; rst during SIDE_G -> 100/100 on the next cycle.
